// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter and access sequencer for the memory/IO decoder port
//
// Purpose:
//   Master 0 (CPU data stage) and master 1 (DMA/loader) share one decoder port.
//   One access is granted at a time. When both masters request, the one that did
//   not own the previous access wins. The decoder port is held stable for 1 cycle
//   for RAM, or 1+IO_WAIT cycles for the IO region. Completion is signalled with a
//   one-cycle ack, and read data is registered per master.
//
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-low reset
//   m0Req/m0Wr/m0Addr/m0WtData       master 0 request bundle, held until m0Ack
//   m0Ack, m0RdData                  master 0 completion pulse and registered read data
//   m1Req/m1Wr/m1Addr/m1WtData       master 1 request bundle, held until m1Ack
//   m1Ack, m1RdData                  master 1 completion pulse and registered read data
//   memCe/memWr/memAddr/wtData       registered decoder access outputs
//   rdData                           decoder read data, combinational from RAM/IO
//   busy                             high while an access is in ACCESS or RESP
//   grant                            index of the master owning the current/last access

module mem_arbiter #(
    parameter int unsigned IO_WAIT = 2,
    parameter logic [31:0] IO_MASK = 32'hF000_0000,
    parameter logic [31:0] IO_BASE = 32'h7000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0Req,
    input  logic        m0Wr,
    input  logic [31:0] m0Addr,
    input  logic [31:0] m0WtData,
    output logic        m0Ack,
    output logic [31:0] m0RdData,
    input  logic        m1Req,
    input  logic        m1Wr,
    input  logic [31:0] m1Addr,
    input  logic [31:0] m1WtData,
    output logic        m1Ack,
    output logic [31:0] m1RdData,
    output logic        memCe,
    output logic        memWr,
    output logic [31:0] memAddr,
    output logic [31:0] wtData,
    input  logic [31:0] rdData,
    output logic        busy,
    output logic        grant
);

    localparam logic [3:0] IO_WAIT_CNT = 4'(IO_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic [3:0]  wait_cnt;

    logic        do_grant;
    logic        sel;
    logic        finish;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic        sel_io;

    assign sel_wr   = sel ? m1Wr     : m0Wr;
    assign sel_addr = sel ? m1Addr   : m0Addr;
    assign sel_data = sel ? m1WtData : m0WtData;
    // IO decode is done once, on the address being latched at grant time.
    assign sel_io   = (sel_addr & IO_MASK) == IO_BASE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        sel        = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (m0Req && m1Req) begin
                    // Tie: the master that did not own the previous access wins.
                    do_grant   = 1'b1;
                    sel        = ~last_grant;
                    state_next = ACCESS;
                end else if (m0Req) begin
                    do_grant   = 1'b1;
                    sel        = 1'b0;
                    state_next = ACCESS;
                end else if (m1Req) begin
                    do_grant   = 1'b1;
                    sel        = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    finish     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memCe      <= 1'b0;
            memWr      <= 1'b0;
            memAddr    <= 32'd0;
            wtData     <= 32'd0;
            m0Ack      <= 1'b0;
            m1Ack      <= 1'b0;
            m0RdData   <= 32'd0;
            m1RdData   <= 32'd0;
            busy       <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 4'd0;
        end else begin
            m0Ack <= 1'b0;
            m1Ack <= 1'b0;
            busy  <= (state_next != IDLE);

            if (do_grant) begin
                memCe      <= 1'b1;
                memWr      <= sel_wr;
                memAddr    <= sel_addr;
                wtData     <= sel_data;
                grant      <= sel;
                last_grant <= sel;
                wait_cnt   <= sel_io ? IO_WAIT_CNT : 4'd0;
            end else if (finish) begin
                // Final ACCESS cycle: rdData is still driven by the held address.
                if (!memWr) begin
                    if (grant) begin
                        m1RdData <= rdData;
                    end else begin
                        m0RdData <= rdData;
                    end
                end
                if (grant) begin
                    m1Ack <= 1'b1;
                end else begin
                    m0Ack <= 1'b1;
                end
                memCe   <= 1'b0;
                memWr   <= 1'b0;
                memAddr <= 32'd0;
                wtData  <= 32'd0;
            end else if (state == ACCESS) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the memory/IO address decoder (the memCe/memWr/memAddr/wtData/rdData port).
- Master 0 is the CPU data-memory stage. Master 1 is the DMA/loader engine.
- Grants one access at a time with round-robin fairness.
- Holds the decoder port stable for a fixed number of cycles: 1 for RAM, 1+IO_WAIT for the IO region.
- Returns read data with a one-cycle ack pulse.

Parameters:
- IO_WAIT, 2, extra ACCESS cycles for IO-region accesses (0..15).
- IO_MASK, 32'hF000_0000, address mask used for IO-region decode.
- IO_BASE, 32'h7000_0000, an access is IO when (addr & IO_MASK) == IO_BASE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0Req  in  1  master 0 request; held until m0Ack.
- m0Wr  in  1  master 0 write (1) / read (0).
- m0Addr  in  32  master 0 byte address.
- m0WtData  in  32  master 0 write data.
- m0Ack  out  1  one-cycle completion pulse to master 0.
- m0RdData  out  32  registered read data for master 0.
- m1Req, m1Wr, m1Addr, m1WtData, m1Ack, m1RdData: same as master 0, for master 1.
- memCe  out  1  decoder chip enable, registered.
- memWr  out  1  decoder write strobe, registered.
- memAddr  out  32  decoder address, registered.
- wtData  out  32  decoder write data, registered.
- rdData  in  32  decoder read data, combinational from RAM/IO.
- busy  out  1  high in ACCESS and RESP.
- grant  out  1  index of the master owning the current/last access.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, lastGrant=1, so master 0 wins the first tie.
- Reset values: memCe=0, memWr=0, memAddr=0, wtData=0, m0Ack=0, m1Ack=0, m0RdData=0, m1RdData=0, busy=0, grant=0, wait counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant that master.
  - Both requesting: grant the master != lastGrant.
  - On grant: register the master's Wr/Addr/WtData onto memWr/memAddr/wtData, set memCe=1, set grant and lastGrant.
  - Load the wait counter with IO_WAIT if the address is IO-region, else 0. Go to ACCESS.
- ACCESS:
  - memCe/memWr/memAddr/wtData are held constant.
  - Counter nonzero: decrement and stay.
  - Counter zero: this is the final ACCESS cycle. If it is a read, sample rdData at the edge into the granted master's RdData register. Then clear memCe/memWr/memAddr/wtData to 0, assert the granted master's Ack, and go to RESP.
- RESP: Ack high for exactly this cycle, then go to IDLE. There is no arbitration in RESP.
- Latency (IDLE samples request in cycle 0):
  - RAM access: ACCESS in cycle 1, ack in cycle 2.
  - IO access: ack in cycle 2+IO_WAIT.
  - Minimum issue interval for back-to-back accesses is 3 cycles (RAM).
- Requester rules:
  - Req, Wr, Addr and WtData stay stable from assertion until the Ack cycle.
  - Req deasserts in the cycle after Ack unless a new access is intended. Req sampled high in IDLE is treated as a new access.
- Write accesses leave RdData unchanged.
- Req dropping during ACCESS is ignored: the access completes and is acked. There is no abort.
- The non-granted master's Ack stays 0. Its RdData is untouched.
- Fairness: a continuously requesting master never waits more than one foreign access.
- Address decode uses the address latched at grant; it is not re-evaluated later.
- Reset asserted mid-ACCESS or mid-RESP: outputs go to their reset values immediately and no Ack is issued.

Test Plan:
1. Reset, then m0 read at 32'h0000_0040 with rdData=32'hDEADBEEF: memCe=1 for 1 cycle, m0Ack in cycle 2, m0RdData=32'hDEADBEEF, m1Ack stays 0.
2. m1 write at 32'h7000_0004 with data 32'h0000_00A5, IO_WAIT=2: memCe=1, memWr=1, memAddr/wtData stable for 3 cycles; m1Ack in cycle 4; m1RdData unchanged (0).
3. m0Req and m1Req high together continuously: grant sequence 0,1,0,1; acks alternate every 3 cycles (RAM addresses).
4. m0 read at 32'h7000_0000 (IO), rdData changes each cycle (1,2,3): m0RdData captures the value present in the final ACCESS cycle (3).
5. m0Req dropped in the first ACCESS cycle of an IO read: access still runs IO_WAIT+1 cycles and m0Ack pulses once.
6. rst asserted during the second ACCESS cycle of an IO access: memCe=0 and busy=0 immediately, no Ack. After release, the first tie goes to m0.
